// File: rtl/pixel_readout.sv
// Row-buffered pixel serializer: captures sensor rows into a small FIFO and streams
// them out one pixel per valid/ready handshake. Optional macro: PIXEL_READOUT_GRAY_DECODE_EN.
package PixelSensorConfig;
   parameter int PIXEL_ARRAY_WIDTH  = 8;
   parameter int PIXEL_ARRAY_HEIGHT = 8;
   parameter int PIXEL_BITS         = 10;
endpackage

module pixel_readout #(
   parameter int COLS  = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
   parameter int ROWS  = PixelSensorConfig::PIXEL_ARRAY_HEIGHT,
   parameter int BITS  = PixelSensorConfig::PIXEL_BITS,
   parameter int DEPTH = 2,
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 NEW_ROW,
   input  logic                 FRAME_FINISHED,
   input  logic [COLS*BITS-1:0] PIXEL_DATA,
   input  logic                 OUT_READY,
   output logic                 OUT_VALID,
   output logic [BITS-1:0]      OUT_DATA,
   output logic [RW-1:0]        OUT_ROW,
   output logic [CW-1:0]        OUT_COL,
   output logic                 OUT_LAST,
   output logic                 OVERFLOW,
   output logic                 dbg_state_o
);

   // Handshake: a pixel transfers at a rising edge where OUT_VALID & OUT_READY; while
   // OUT_VALID is high without OUT_READY, every OUT_* field holds and OUT_VALID stays high.

   typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_e;

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NW = $clog2(DEPTH + 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
   localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);
   localparam logic [NW-1:0] ONE_CNT  = NW'(1);

   logic [COLS*BITS-1:0] mem_q     [DEPTH];
   logic [RW-1:0]        idx_mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
   logic [NW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] cap_row_q, cap_row_d;
   state_e        state_q, state_d;
   logic          valid_q, valid_d;
   logic [BITS-1:0] data_q, data_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          last_q, last_d;
   logic          ovf_q, ovf_d;

   logic hs, pop, push;
   logic                 ld_en;
   logic [COLS*BITS-1:0] ld_pix;
   logic [RW-1:0]        ld_row;
   logic [CW-1:0]        ld_col;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [BITS-1:0] pick(input logic [COLS*BITS-1:0] r,
                                            input logic [CW-1:0] c);
      logic [BITS-1:0] v;
      v = '0;
      for (int i = 0; i < COLS; i++) begin
         if (c == CW'(i)) v = r[i*BITS +: BITS];
      end
      return v;
   endfunction

`ifdef PIXEL_READOUT_GRAY_DECODE_EN
   function automatic logic [BITS-1:0] fmt(input logic [BITS-1:0] g);
      logic [BITS-1:0] b;
      b = '0;
      b[BITS-1] = g[BITS-1];
      for (int i = BITS - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
`else
   function automatic logic [BITS-1:0] fmt(input logic [BITS-1:0] g);
      return g;
   endfunction
`endif

   // The head row stays in the FIFO until its last column is accepted.
   assign hs     = valid_q & OUT_READY;
   assign pop    = (state_q == S_STREAM) & hs & (col_q == LAST_COL);
   assign push   = NEW_ROW & ((cnt_q != FULL_CNT) | pop);
   assign rd_nxt = ptr_inc(rd_ptr_q);

   always_comb begin
      wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d  = pop ? rd_nxt : rd_ptr_q;
      cnt_d     = cnt_q;
      if (push && !pop) cnt_d = cnt_q + 1'b1;
      else if (!push && pop) cnt_d = cnt_q - 1'b1;
      cap_row_d = cap_row_q;
      if (FRAME_FINISHED) cap_row_d = '0;
      else if (NEW_ROW) cap_row_d = (cap_row_q == LAST_ROW) ? '0 : cap_row_q + 1'b1;
      ovf_d     = ovf_q | (NEW_ROW & ~push);
   end

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      ld_en   = 1'b0;
      ld_pix  = mem_q[rd_ptr_q];
      ld_row  = idx_mem_q[rd_ptr_q];
      ld_col  = '0;
      case (state_q)
         S_IDLE: begin
            if (cnt_q != '0) begin
               state_d = S_STREAM;
               valid_d = 1'b1;
               ld_en   = 1'b1;
            end
         end
         S_STREAM: begin
            if (hs) begin
               if (col_q != LAST_COL) begin
                  ld_en  = 1'b1;
                  ld_col = col_q + 1'b1;
               end else if (cnt_q > ONE_CNT) begin
                  ld_en  = 1'b1;
                  ld_pix = mem_q[rd_nxt];
                  ld_row = idx_mem_q[rd_nxt];
               end else if (push) begin
                  // Row arriving on the freeing edge goes straight to the output.
                  ld_en  = 1'b1;
                  ld_pix = PIXEL_DATA;
                  ld_row = cap_row_q;
               end else begin
                  state_d = S_IDLE;
                  valid_d = 1'b0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      data_d = ld_en ? fmt(pick(ld_pix, ld_col)) : data_q;
      row_d  = ld_en ? ld_row : row_q;
      col_d  = ld_en ? ld_col : col_q;
      last_d = ld_en ? ((ld_row == LAST_ROW) && (ld_col == LAST_COL)) : last_q;
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wr_ptr_q]     <= PIXEL_DATA;
         idx_mem_q[wr_ptr_q] <= cap_row_q;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         cap_row_q <= '0;
         state_q   <= S_IDLE;
         valid_q   <= 1'b0;
         data_q    <= '0;
         row_q     <= '0;
         col_q     <= '0;
         last_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         cap_row_q <= cap_row_d;
         state_q   <= state_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         row_q     <= row_d;
         col_q     <= col_d;
         last_q    <= last_d;
         ovf_q     <= ovf_d;
      end
   end

   assign OUT_VALID   = valid_q;
   assign OUT_DATA    = data_q;
   assign OUT_ROW     = row_q;
   assign OUT_COL     = col_q;
   assign OUT_LAST    = last_q;
   assign OVERFLOW    = ovf_q;
   assign dbg_state_o = (state_q == S_STREAM);

endmodule

// File: tb/tb_pixel_readout.sv
// Bench for pixel_readout: scoreboard of expected pixels filled when rows are driven,
// checked by a monitor as the serializer emits them.
module tb_pixel_readout;
   localparam int COLS  = 2;
   localparam int ROWS  = 4;
   localparam int BITS  = 8;
   localparam int DEPTH = 2;
   localparam int RW    = 2;
   localparam int CW    = 1;
   localparam int EW    = RW + CW + BITS + 1;

   logic                 CLK = 1'b0;
   logic                 RESET, NEW_ROW, FRAME_FINISHED, OUT_READY;
   logic [COLS*BITS-1:0] PIXEL_DATA;
   logic                 OUT_VALID, OUT_LAST, OVERFLOW, dbg_state_o;
   logic [BITS-1:0]      OUT_DATA;
   logic [RW-1:0]        OUT_ROW;
   logic [CW-1:0]        OUT_COL;

   logic [EW-1:0] exp_q[$];
   int vectors = 0;
   int miscompares = 0;
   int cap_row = 0;

   pixel_readout #(.COLS(COLS), .ROWS(ROWS), .BITS(BITS), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RESET(RESET), .NEW_ROW(NEW_ROW), .FRAME_FINISHED(FRAME_FINISHED),
      .PIXEL_DATA(PIXEL_DATA), .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID),
      .OUT_DATA(OUT_DATA), .OUT_ROW(OUT_ROW), .OUT_COL(OUT_COL), .OUT_LAST(OUT_LAST),
      .OVERFLOW(OVERFLOW), .dbg_state_o(dbg_state_o)
   );

   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [BITS-1:0] exp_pix(input logic [BITS-1:0] g);
`ifdef PIXEL_READOUT_GRAY_DECODE_EN
      logic [BITS-1:0] b;
      b = g;
      for (int s = 1; s < BITS; s++) b = b ^ (g >> s);
      return b;
`else
      return g;
`endif
   endfunction

   function automatic logic [COLS*BITS-1:0] rand_row();
      logic [COLS*BITS-1:0] r;
      for (int c = 0; c < COLS; c++) r[c*BITS +: BITS] = BITS'($urandom_range(1, 255));
      return r;
   endfunction

   task automatic push_exp(input int row, input logic [COLS*BITS-1:0] pix);
      logic [RW-1:0]   r;
      logic [CW-1:0]   cc;
      logic [BITS-1:0] d;
      logic            l;
      for (int c = 0; c < COLS; c++) begin
         r  = RW'(row);
         cc = CW'(c);
         d  = exp_pix(pix[c*BITS +: BITS]);
         l  = (row == ROWS - 1) && (c == COLS - 1);
         exp_q.push_back({r, cc, d, l});
      end
   endtask

   task automatic send_row(input logic [COLS*BITS-1:0] pix, input bit accept);
      PIXEL_DATA = pix;
      NEW_ROW    = 1'b1;
      if (accept) push_exp(cap_row, pix);
      cap_row = (cap_row + 1) % ROWS;
      @(posedge CLK); #1;
      NEW_ROW = 1'b0;
   endtask

   task automatic frame_finish();
      FRAME_FINISHED = 1'b1;
      @(posedge CLK); #1;
      FRAME_FINISHED = 1'b0;
      cap_row = 0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge CLK); #1;
         n++;
      end
      check("drain", exp_q.size(), 0);
      @(posedge CLK); #1;
      check("idle_valid", OUT_VALID, 0);
   endtask

   logic [EW-1:0] e;
   always @(negedge CLK) begin
      if (!RESET && OUT_VALID) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pixel", 1, 0);
         end else begin
            e = exp_q[0];
            check("out_row",  OUT_ROW,  e[EW-1 -: RW]);
            check("out_col",  OUT_COL,  e[BITS+1 +: CW]);
            check("out_data", OUT_DATA, e[1 +: BITS]);
            check("out_last", OUT_LAST, e[0]);
            if (OUT_READY) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [COLS*BITS-1:0] a;
      RESET = 1'b1; NEW_ROW = 1'b0; FRAME_FINISHED = 1'b0; OUT_READY = 1'b0;
      PIXEL_DATA = '0;
      repeat (2) @(posedge CLK); #1;
      check("rst_valid", OUT_VALID, 0);
      check("rst_data", OUT_DATA, 0);
      check("rst_row", OUT_ROW, 0);
      check("rst_col", OUT_COL, 0);
      check("rst_last", OUT_LAST, 0);
      check("rst_ovf", OVERFLOW, 0);
      check("rst_state", dbg_state_o, 0);
      RESET = 1'b0;
      @(posedge CLK); #1;

      // Known gray pair, latency of one edge after capture.
      OUT_READY = 1'b1;
      a = {8'h03, 8'h80};
      send_row(a, 1);
      check("lat_k_valid", OUT_VALID, 0);
      @(posedge CLK); #1;
      check("lat_k1_valid", OUT_VALID, 1);
      check("lat_k1_col", OUT_COL, 0);
      check("lat_k1_data", OUT_DATA, exp_pix(8'h80));
      drain();

      // Stall on column 0 for five cycles.
      OUT_READY = 1'b0;
      send_row(rand_row(), 1);
      @(posedge CLK); #1;
      check("stall_valid", OUT_VALID, 1);
      check("stall_state", dbg_state_o, 1);
      repeat (5) @(posedge CLK);
      #1;
      OUT_READY = 1'b1;
      drain();

      // Full frame, then FRAME_FINISHED restarting the row index.
      frame_finish();
      for (int r = 0; r < ROWS; r++) begin
         send_row(rand_row(), 1);
         @(posedge CLK); #1;
      end
      drain();
      send_row(rand_row(), 1);
      @(posedge CLK); #1;
      send_row(rand_row(), 1);
      frame_finish();
      send_row(rand_row(), 1);
      drain();
      check("ovf_clear_frame", OVERFLOW, 0);

      // FIFO full with a capture on the freeing handshake.
      OUT_READY = 1'b0;
      send_row(rand_row(), 1);
      send_row(rand_row(), 1);
      check("full_valid", OUT_VALID, 1);
      OUT_READY = 1'b1;
      @(posedge CLK); #1;
      send_row(rand_row(), 1);
      drain();
      check("ovf_coincident", OVERFLOW, 0);

      // Asynchronous reset mid-row.
      OUT_READY = 1'b0;
      send_row({8'h5A, 8'hA5}, 1);
      @(posedge CLK); #3;
      check("pre_rst_valid", OUT_VALID, 1);
      RESET = 1'b1;
      exp_q.delete();
      cap_row = 0;
      #1;
      check("arst_valid", OUT_VALID, 0);
      check("arst_data", OUT_DATA, 0);
      check("arst_row", OUT_ROW, 0);
      check("arst_col", OUT_COL, 0);
      check("arst_last", OUT_LAST, 0);
      @(posedge CLK); #1;
      RESET = 1'b0;
      OUT_READY = 1'b1;
      send_row(rand_row(), 1);
      @(posedge CLK); #1;
      check("post_rst_row", OUT_ROW, 0);
      check("post_rst_col", OUT_COL, 0);
      drain();

      // Overflow: third row dropped while output is stalled.
      OUT_READY = 1'b0;
      frame_finish();
      send_row(rand_row(), 1);
      send_row(rand_row(), 1);
      check("ovf_before_drop", OVERFLOW, 0);
      send_row(rand_row(), 0);
      check("ovf_set", OVERFLOW, 1);
      repeat (3) @(posedge CLK);
      #1;
      OUT_READY = 1'b1;
      drain();
      send_row(rand_row(), 1);
      drain();
      check("ovf_sticky", OVERFLOW, 1);

      check("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
